seg_scan_mux: RTL and testbench

Time-multiplexed scan controller for an NDIGITS common-anode 7-segment display. It sits directly upstream of the seven_seg decoder and drives the decoder's 5-bit code input one digit at a time, together with the active-low digit enables. Digit values are double-buffered and updated only at frame boundaries, so the display never tears. Optional leading-zero blanking is included, plus a per-slot blanking interval that prevents ghosting between digits.

---
 rtl/seg_scan_if.sv | 30 +++
 rtl/seg_scan_mux.sv | 125 ++++++++++++
 tb/tb_seg_scan_mux.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Digit-source / scan-controller bus for seg_scan_mux.
// The source (master) drives load, digits and lz_en; the scanner (slave) drives the display outputs.
interface seg_scan_if #(
    parameter int unsigned NDIGITS = 4
) ();
    logic                 load;
    logic [5*NDIGITS-1:0] digits_in;
    logic                 lz_en;
    logic [4:0]           code;
    logic [NDIGITS-1:0]   an_n;
    logic                 frame_tick;

    modport master (
        output load,
        output digits_in,
        output lz_en,
        input  code,
        input  an_n,
        input  frame_tick
    );

    modport slave (
        input  load,
        input  digits_in,
        input  lz_en,
        output code,
        output an_n,
        output frame_tick
    );
endinterface

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Digit data is double-buffered and swapped only at frame boundaries.
module seg_scan_mux #(
    parameter int unsigned NDIGITS   = 4,
    parameter int unsigned DIV       = 1000,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    seg_scan_if.slave bus
);
    localparam int unsigned CODE_W = 5;
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W  = $clog2(NDIGITS);

    typedef logic [NDIGITS-1:0][CODE_W-1:0] digits_t;

    logic [DIV_W-1:0]   r_div_cnt;
    logic [DIV_W-1:0]   w_div_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_idx_nxt;
    digits_t            r_pend;
    digits_t            w_pend_nxt;
    logic               r_pend_vld;
    logic               w_pend_vld_nxt;
    digits_t            r_digits_q;
    digits_t            w_digits_nxt;
    digits_t            w_digits_in;
    logic [CODE_W-1:0]  r_code;
    logic [CODE_W-1:0]  w_code_nxt;
    logic [NDIGITS-1:0] r_an_n;
    logic [NDIGITS-1:0] w_an_n_nxt;
    logic               r_frame_tick;
    logic               w_slot_end;
    logic               w_frame_end;
    logic               w_blank;
    logic               w_suppress;

    assign w_digits_in = bus.digits_in;
    assign w_slot_end  = (r_div_cnt == DIV_W'(DIV - 1));
    assign w_frame_end = w_slot_end && (r_idx == IDX_W'(NDIGITS - 1));

    // Slot/digit counters and the double buffer; a load on the boundary bypasses pend.
    always_comb begin
        w_div_nxt      = r_div_cnt + DIV_W'(1);
        w_idx_nxt      = r_idx;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        w_digits_nxt   = r_digits_q;
        if (w_slot_end) begin
            w_div_nxt = '0;
            w_idx_nxt = w_frame_end ? '0 : r_idx + IDX_W'(1);
        end
        if (bus.load) begin
            w_pend_nxt = w_digits_in;
        end
        if (w_frame_end) begin
            w_pend_vld_nxt = 1'b0;
            if (bus.load) begin
                w_digits_nxt = w_digits_in;
            end else if (r_pend_vld) begin
                w_digits_nxt = r_pend;
            end
        end else if (bus.load) begin
            w_pend_vld_nxt = 1'b1;
        end
    end

    // Digit k>=1 is blanked when it and every more-significant digit are zero.
    always_comb begin
        logic all_zero;
        all_zero   = 1'b1;
        w_suppress = 1'b0;
        for (int k = int'(NDIGITS) - 1; k >= 1; k--) begin
            all_zero = all_zero && (w_digits_nxt[k] == '0);
            if (IDX_W'(k) == w_idx_nxt) begin
                w_suppress = all_zero;
            end
        end
        w_suppress = w_suppress && bus.lz_en;
    end

    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign w_blank = 1'b0;
        end else begin : g_blank
            assign w_blank = (w_div_nxt < DIV_W'(BLANK_CYC));
        end
    endgenerate

    // Outputs are computed from next-cycle state so they line up with the counters.
    always_comb begin
        w_code_nxt = w_digits_nxt[w_idx_nxt];
        w_an_n_nxt = '1;
        if (!w_blank && !w_suppress) begin
            w_an_n_nxt[w_idx_nxt] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt    <= '0;
            r_idx        <= '0;
            r_pend       <= '0;
            r_pend_vld   <= 1'b0;
            r_digits_q   <= '0;
            r_code       <= '0;
            r_an_n       <= '1;
            r_frame_tick <= 1'b0;
        end else begin
            r_div_cnt    <= w_div_nxt;
            r_idx        <= w_idx_nxt;
            r_pend       <= w_pend_nxt;
            r_pend_vld   <= w_pend_vld_nxt;
            r_digits_q   <= w_digits_nxt;
            r_code       <= w_code_nxt;
            r_an_n       <= w_an_n_nxt;
            r_frame_tick <= w_frame_end;
        end
    end

    assign bus.code       = r_code;
    assign bus.an_n       = r_an_n;
    assign bus.frame_tick = r_frame_tick;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: vector table of frame contents plus hand-written boundary,
// tearing and reset sequences, checked cycle-by-cycle through an expectation queue.
module tb_seg_scan_mux;
    localparam int unsigned NDIGITS   = 4;
    localparam int unsigned DIV       = 8;
    localparam int unsigned BLANK_CYC = 2;
    localparam int          FRAME     = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    seg_scan_if #(.NDIGITS(NDIGITS)) bus ();

    seg_scan_mux #(
        .NDIGITS  (NDIGITS),
        .DIV      (DIV),
        .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int         cyc;
        logic [4:0] code;
        logic [3:0] an_n;
        logic       ft;
        string      tag;
    } exp_t;

    typedef struct {
        string       name;
        logic        lz;
        logic [19:0] digits;
        logic [3:0]  lit;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[9];
    int   cyc;
    int   n_checks = 0;
    int   n_errors = 0;

    // Cycles since the last reset release; cycle 0 is the first cycle out of reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got code=%h an_n=%b tick=%b expected code=%h an_n=%b tick=%b",
                     name, got[9:5], got[4:1], got[0], exp[9:5], exp[4:1], exp[0]);
        end
    endtask

    task automatic mon_loop();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                    e = sb_q.pop_front();
                    n_checks++;
                    n_errors++;
                    $display("FAIL %s missed sample for cyc=%0d (now %0d)", e.tag, e.cyc, cyc);
                end
                if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
                    e = sb_q.pop_front();
                    check($sformatf("%s cyc=%0d", e.tag, e.cyc),
                          {bus.code, bus.an_n, bus.frame_tick}, {e.code, e.an_n, e.ft});
                end
            end
        end
    endtask

    // Expected outputs for cycles c_lo..c_hi of frame f; lit marks slots that are not suppressed.
    task automatic push_frame(input int f, input logic [19:0] d, input logic [3:0] lit,
                              input string tag, input int c_lo, input int c_hi);
        exp_t e;
        for (int c = c_lo; c <= c_hi; c++) begin
            int s;
            int k;
            s      = c / int'(DIV);
            k      = c % int'(DIV);
            e.cyc  = f * FRAME + c;
            e.code = d[s*5 +: 5];
            e.an_n = (k < int'(BLANK_CYC) || !lit[s]) ? 4'hF : 4'(~(4'b0001 << s));
            e.ft   = (c == 0) && (f > 0);
            e.tag  = tag;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_cyc(input int target);
        int budget;
        budget = 0;
        while (cyc < target) begin
            @(posedge clk);
            #1;
            budget++;
            if (budget > 400) begin
                n_checks++;
                n_errors++;
                $display("FAIL wait_cyc timeout target=%0d now=%0d", target, cyc);
                return;
            end
        end
    endtask

    task automatic load_digits(input logic [19:0] d, input logic lz);
        bus.digits_in = d;
        bus.lz_en     = lz;
        bus.load      = 1'b1;
        @(posedge clk);
        #1;
        bus.load      = 1'b0;
    endtask

    initial begin
        int f;
        int budget;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.lz_en     = 1'b0;
        fork
            mon_loop();
        join_none

        vecs[0] = '{"lz_95",      1'b1, {5'd0,  5'd0,  5'd9, 5'd5}, 4'b0011};
        vecs[1] = '{"nolz_95",    1'b0, {5'd0,  5'd0,  5'd9, 5'd5}, 4'b1111};
        vecs[2] = '{"lz_zero",    1'b1, {5'd0,  5'd0,  5'd0, 5'd0}, 4'b0001};
        vecs[3] = '{"lz_1f_top",  1'b1, {5'h1F, 5'd0,  5'd0, 5'd0}, 4'b1111};
        vecs[4] = '{"lz_7_d2",    1'b1, {5'd0,  5'd7,  5'd0, 5'd0}, 4'b0111};
        vecs[5] = '{"lz_3_d0",    1'b1, {5'd0,  5'd0,  5'd0, 5'd3}, 4'b0001};
        vecs[6] = '{"lz_1_d1",    1'b1, {5'd0,  5'd0,  5'd1, 5'd0}, 4'b0011};
        vecs[7] = '{"lz_10_d2",   1'b1, {5'd0,  5'h10, 5'd0, 5'd0}, 4'b0111};
        vecs[8] = '{"nolz_8_top", 1'b0, {5'd8,  5'd0,  5'd0, 5'd0}, 4'b1111};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.code, bus.an_n, bus.frame_tick}, {5'h00, 4'hF, 1'b0});
        rst_n = 1'b1;
        push_frame(0, 20'h0, 4'hF, "idle_f0", 0, 31);
        push_frame(1, 20'h0, 4'hF, "idle_f1", 0, 31);
        wait_cyc(FRAME + 31);

        foreach (vecs[i]) begin
            wait_cyc((cyc / FRAME + 1) * FRAME + 12);
            f = cyc / FRAME;
            load_digits(vecs[i].digits, vecs[i].lz);
            push_frame(f + 1, vecs[i].digits, vecs[i].lit, vecs[i].name, 0, 31);
            wait_cyc((f + 1) * FRAME + 31);
        end

        // Mid-frame load must not tear the frame in progress.
        wait_cyc((cyc / FRAME + 1) * FRAME + 12);
        f = cyc / FRAME;
        push_frame(f, vecs[8].digits, 4'hF, "tear_old", 13, 31);
        load_digits({5'd1, 5'd2, 5'd3, 5'd4}, 1'b0);
        push_frame(f + 1, {5'd1, 5'd2, 5'd3, 5'd4}, 4'hF, "tear_new", 0, 31);
        wait_cyc((f + 1) * FRAME + 31);

        // Load on the boundary cycle lands in the frame that is just starting.
        load_digits({5'd0, 5'd0, 5'h0C, 5'h0D}, 1'b1);
        push_frame(f + 2, {5'd0, 5'd0, 5'h0C, 5'h0D}, 4'b0011, "bnd_load", 0, 31);
        wait_cyc((f + 2) * FRAME + 31);

        // Two loads in one frame: only the later one is displayed.
        f = f + 3;
        wait_cyc(f * FRAME + 10);
        load_digits({5'd1, 5'd1, 5'd1, 5'd1}, 1'b0);
        wait_cyc(f * FRAME + 20);
        load_digits({5'd2, 5'd5, 5'd3, 5'd0}, 1'b0);
        push_frame(f + 1, {5'd2, 5'd5, 5'd3, 5'd0}, 4'hF, "two_load", 0, 31);
        push_frame(f + 2, {5'd2, 5'd5, 5'd3, 5'd0}, 4'hF, "pre_rst", 0, 19);

        // Reset in slot 2 with a load pending: outputs clear at once and the load is dropped.
        wait_cyc((f + 2) * FRAME + 18);
        load_digits({5'd9, 5'd9, 5'd9, 5'd9}, 1'b0);
        wait_cyc((f + 2) * FRAME + 20);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", {bus.code, bus.an_n, bus.frame_tick}, {5'h00, 4'hF, 1'b0});
        repeat (3) @(posedge clk);
        #1;
        check("held_reset_outputs", {bus.code, bus.an_n, bus.frame_tick}, {5'h00, 4'hF, 1'b0});
        rst_n = 1'b1;
        push_frame(0, 20'h0, 4'hF, "post_rst_f0", 0, 31);
        push_frame(1, 20'h0, 4'hF, "post_rst_f1", 0, 31);
        wait_cyc(FRAME + 31);

        budget = 0;
        while (sb_q.size() > 0 && budget < 200) begin
            @(posedge clk);
            budget++;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain %0d expectations left unchecked", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
